// File: rtl/idli_sqi_ctrl.sv
// Quad-mode SQI sequencer: one nibble lane per attached SRAM, shared chip select and SCK enable.
// Each request runs command, address and optional dummy phases, then a back-pressured data burst.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | cs_n high, ready for a request
//   S_CMD   | two cycles driving the command byte, high nibble first
//   S_ADDR  | ADDR_W/4 cycles driving the address, MSB nibble first
//   S_DUMMY | read turnaround, pins released, SCK still running
//   S_DATA  | data beats; SCK runs only when the data side can move
//   S_GAP   | cs_n high for CS_IDLE_CYC cycles before returning to idle
module idli_sqi_ctrl #(
    parameter int SQI_NUM     = 2,
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 8,
    parameter int DUMMY_CYC   = 2,
    parameter int CS_IDLE_CYC = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_vld,
    output logic                   o_req_rdy,
    input  logic                   i_req_wr,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [LEN_W-1:0]       i_req_len,
    input  logic                   i_wdata_vld,
    input  logic [4*SQI_NUM-1:0]   i_wdata,
    output logic                   o_wdata_rdy,
    output logic                   o_rdata_vld,
    output logic [4*SQI_NUM-1:0]   o_rdata,
    input  logic                   i_rdata_rdy,
    output logic                   o_busy,
    output logic                   o_sqi_cs_n,
    output logic                   o_sqi_sck_en,
    output logic                   o_sqi_oe,
    output logic [4*SQI_NUM-1:0]   o_sqi_out,
    input  logic [4*SQI_NUM-1:0]   i_sqi_in
);

    localparam int ADDR_NIB = ADDR_W / 4;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               beat;
    logic               rd_cap;
    logic [3:0]         nib;
    logic [7:0]         cmd_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            o_rdata_vld <= 1'b0;
            o_rdata     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            o_rdata_vld <= rd_cap;
            if (rd_cap) begin
                o_rdata <= i_sqi_in;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        o_req_rdy    = 1'b0;
        o_busy       = (state_q != S_IDLE);
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        o_sqi_oe     = 1'b0;
        o_sqi_out    = '0;
        o_wdata_rdy  = 1'b0;
        beat         = 1'b0;
        rd_cap       = 1'b0;
        nib          = '0;
        cmd_byte     = wr_q ? 8'h02 : 8'h03;

        case (state_q)
            S_IDLE: begin
                // Holding off ready during reset keeps a request from slipping in on the reset edge.
                o_req_rdy = !i_rst;
                if (i_req_vld && !i_rst) begin
                    wr_d    = i_req_wr;
                    addr_d  = i_req_addr;
                    beat_d  = i_req_len;
                    cnt_d   = CNT_W'(1);
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_oe     = 1'b1;
                nib          = (cnt_q != '0) ? cmd_byte[7:4] : cmd_byte[3:0];
                o_sqi_out    = {SQI_NUM{nib}};
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(ADDR_NIB - 1);
                    state_d = S_ADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_oe     = 1'b1;
                nib          = 4'(addr_q >> {cnt_q, 2'b00});
                o_sqi_out    = {SQI_NUM{nib}};
                if (cnt_q == '0) begin
                    if (wr_q || DUMMY_CYC == 0) begin
                        state_d = S_DATA;
                    end else begin
                        cnt_d   = CNT_W'(DUMMY_CYC - 1);
                        state_d = S_DUMMY;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DUMMY: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DATA: begin
                o_sqi_cs_n = 1'b0;
                if (wr_q) begin
                    o_sqi_oe    = 1'b1;
                    o_sqi_out   = i_wdata;
                    beat        = i_wdata_vld;
                    o_wdata_rdy = i_wdata_vld;
                end else begin
                    beat   = i_rdata_rdy;
                    rd_cap = i_rdata_rdy;
                end
                o_sqi_sck_en = beat;
                if (beat) begin
                    if (beat_q == '0) begin
                        cnt_d   = CNT_W'(CS_IDLE_CYC - 1);
                        state_d = S_GAP;
                    end else begin
                        beat_d = beat_q - 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/idli_sqi_ctrl.md
Name: idli_sqi_ctrl

Overview:
- Parametrised SQI memory sequencer between the idli core and SQI_NUM SPI/SQI SRAMs in quad mode.
- All memories share chip select and clock enable.
- Each memory carries one nibble lane of every beat, generalising the fixed two-memory lo/hi nibble split to any lane count.
- Runs command, address and dummy phases, then streams a burst of data beats with backpressure in both directions.

Parameters:
- SQI_NUM, 2, number of attached memories / nibble lanes (1..8).
- ADDR_W, 24, address bits sent to each memory; must be a multiple of 4.
- LEN_W, 8, width of burst-length field.
- DUMMY_CYC, 2, dummy cycles between address and read data.
- CS_IDLE_CYC, 1, minimum cycles chip select is held high between transactions (>=1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_vld  in  1  transaction request valid
- o_req_rdy  out  1  controller can accept a request
- i_req_wr  in  1  1=write, 0=read
- i_req_addr  in  ADDR_W  start address, same value sent to every memory
- i_req_len  in  LEN_W  burst length minus one, in beats
- i_wdata_vld  in  1  write beat valid
- i_wdata  in  4*SQI_NUM  write beat; lane k = bits [4k+3:4k] = memory k
- o_wdata_rdy  out  1  write beat consumed this cycle
- o_rdata_vld  out  1  read beat valid
- o_rdata  out  4*SQI_NUM  read beat, same lane mapping
- i_rdata_rdy  in  1  consumer accepts a read beat next cycle
- o_busy  out  1  transaction in progress (state != IDLE)
- o_sqi_cs_n  out  1  shared chip select, active low
- o_sqi_sck_en  out  1  SCK edge enable for this cycle
- o_sqi_oe  out  1  controller drives data pins
- o_sqi_out  out  4*SQI_NUM  data to memories
- i_sqi_in  in  4*SQI_NUM  data from memories

Behaviour:
- Reset values: cs_n=1, sck_en=0, oe=0, sqi_out=0, rdata_vld=0, rdata=0, wdata_rdy=0, busy=0, req_rdy=0; state goes to IDLE.
- Reset mid-transaction aborts immediately: cs_n=1 the next cycle; no further beats are emitted.
- States: IDLE, CMD, ADDR, DUMMY, DATA, GAP.
- IDLE: req_rdy=1. A request is accepted when vld&&rdy. On acceptance, latch wr, addr and len into a beat counter; go to CMD. cs_n falls on the same edge.
- CMD: 2 cycles, oe=1, sck_en=1. All lanes drive the command byte, high nibble first: READ=0x03, WRITE=0x02.
- ADDR: ADDR_W/4 cycles, MSB nibble first, replicated on all lanes.
- From ADDR: write -> DATA. Read -> DUMMY, or DATA directly when DUMMY_CYC=0.
- DUMMY: DUMMY_CYC cycles, oe=0, sck_en=1.
- DATA, write path:
  - oe=1, sqi_out=i_wdata, sck_en=i_wdata_vld, wdata_rdy=i_wdata_vld.
  - When vld=0, the state and counter hold with no SCK edge (stall).
- DATA, read path:
  - oe=0, sck_en=i_rdata_rdy.
  - In each cycle with sck_en=1, i_sqi_in is registered into o_rdata, and o_rdata_vld=1 in the following cycle. Latency is exactly 1 cycle.
  - rdata_vld=0 otherwise.
- Beat counter counts down on each sck_en beat. The beat taken at count 0 is last, then go to GAP. Total beats = i_req_len+1; len=0 gives 1 beat, len=2^LEN_W-1 gives 2^LEN_W beats.
- GAP: cs_n=1, sck_en=0, oe=0 for CS_IDLE_CYC cycles, then IDLE. The last read beat's rdata_vld appears during the first GAP cycle.
- Address is not incremented by the controller; the memories auto-increment in sequential mode.
- A request presented while busy waits (req_rdy=0). Request signals are sampled only on acceptance.
- Back-to-back requests: the minimum gap from the last data beat to the next CMD is CS_IDLE_CYC+1 cycles (GAP plus one IDLE cycle).

Test Plan:
- Read, SQI_NUM=2, addr=0x000123, len=0, rdata_rdy=1, i_sqi_in=0xA5 during the data cycle:
  - sqi_out sequence is 0x00, 0x33, then nibbles 0,0,0,1,2,3 on both lanes (0x00, 0x00, 0x00, 0x11, 0x22, 0x33).
  - 2 dummy cycles with oe=0.
  - o_rdata=0xA5 one cycle later.
  - cs_n high for 1 cycle; 12 cycles from accept to IDLE.
- Write, len=3, wdata_vld deasserted for 2 cycles after beat 1 -> exactly 4 wdata_rdy pulses; sck_en=0 and sqi_out ignored during the stall; command nibbles 0x00, 0x22.
- Read, len=2, rdata_rdy low for 3 cycles mid-burst -> no SCK edges and no rdata_vld during the stall; beats delivered in order with no duplicates.
- Reset asserted in ADDR cycle 3 -> next cycle cs_n=1, busy=0, oe=0; the next request restarts at CMD.
- Boundary, len=0xFF write -> exactly 256 beats, then GAP.
- Back-to-back requests -> second CMD is exactly CS_IDLE_CYC+1 cycles after the first's last beat.
- Sweep SQI_NUM=1 and 4 -> lane mapping correct.
